// File: rtl/uart_sched_pkg.sv
// ---------------------------------------------------------------------------
// uart_sched_pkg
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// frame length constants, source id bytes, default frame header and the
// checksum helper.
// Build option: UART_SCHED_CKSUM_EN appends a checksum byte (9-byte frames);
// without it, frames are 8 bytes and no checksum logic exists.
// ---------------------------------------------------------------------------
package uart_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_NEXT
  } state_t;

  localparam int FRAME_LEN_BASE  = 8;
  localparam int FRAME_LEN_CKSUM = 9;

`ifdef UART_SCHED_CKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CKSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif

  localparam int PAYLOAD_W = 43;

  localparam logic [7:0] SRC_ID0        = 8'h00;
  localparam logic [7:0] SRC_ID1        = 8'h01;
  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

`ifdef UART_SCHED_CKSUM_EN
  // XOR of the seven bytes following the header (source id + payload).
  function automatic logic [7:0] xorBytes(input logic [55:0] bytes);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 7; i++) begin
      acc = acc ^ bytes[8*i +: 8];
    end
    return acc;
  endfunction
`endif

endpackage

// File: rtl/uart_sched_rr_arb.sv
// ---------------------------------------------------------------------------
// uart_sched_rr_arb
// Two-way round-robin arbiter (purely combinational).
// Ports:
//   i_req      - request bits from source 0 and source 1
//   i_rr       - current priority pointer (source that wins a tie)
//   o_grant    - index of the granted source (only meaningful if |i_req)
//   o_nextRr   - pointer value to store after this grant
// ---------------------------------------------------------------------------
module uart_sched_rr_arb (
  input  logic [1:0] i_req,
  input  logic       i_rr,
  output logic       o_grant,
  output logic       o_nextRr
);

  // A tie goes to the pointer; a lone request simply wins. Either way the
  // pointer then moves to the source that was not served.
  always_comb begin
    o_grant = 1'b0;
    if (i_req == 2'b11) begin
      o_grant = i_rr;
    end else begin
      o_grant = i_req[1];
    end
    o_nextRr = ~o_grant;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Schedules position frames from two sources onto a byte-wide UART
// transmitter. Frame: HEADER, source id, 6 payload bytes (43-bit payload
// zero-extended to 48 bits, MSB first), optional checksum byte.
// Build option: UART_SCHED_CKSUM_EN adds the checksum byte (XOR of the
// source id and payload bytes).
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   req_i         - per-source level requests, held until acked
//   pos0_i/pos1_i - 43-bit payloads for source 0 / source 1
//   ack_o         - one-cycle pulse when a source's payload is latched
//   tx_busy       - transmitter busy
//   tx_data       - byte to transmitter (holds last byte sent)
//   tx_pluse      - one-cycle transmit strobe, tx_data valid with it
//   frame_busy_o  - a frame is in progress
//   err_o         - sticky: tx_busy failed to rise within BUSY_WAIT cycles
// ---------------------------------------------------------------------------
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter logic [7:0] HEADER    = DEFAULT_HEADER,
  parameter int         BUSY_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_i,
  input  logic [PAYLOAD_W-1:0] pos0_i,
  input  logic [PAYLOAD_W-1:0] pos1_i,
  output logic [1:0]           ack_o,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 tx_pluse,
  output logic                 frame_busy_o,
  output logic                 err_o
);

  localparam int FRAME_W = FRAME_LEN * 8;
  localparam int CNT_W   = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(BUSY_WAIT - 1);
  localparam logic [3:0]       LAST_IDX  = 4'(FRAME_LEN - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_rr;
  logic                 r_grant;
  logic [3:0]           r_idx;
  logic [FRAME_W-1:0]   r_frame;
  logic [CNT_W-1:0]     r_waitCnt;
  logic                 r_err;
  logic [7:0]           r_lastData;

  logic                 w_arbGrant;
  logic                 w_arbNextRr;
  logic                 w_pulse;
  logic                 w_timeout;
  logic [1:0]           w_ack;
  logic [7:0]           w_curByte;
  logic [7:0]           w_srcId;
  logic [47:0]          w_payload;
  logic [FRAME_W-1:0]   w_frameInit;

  uart_sched_rr_arb u_arb (
    .i_req    (req_i),
    .i_rr     (r_rr),
    .o_grant  (w_arbGrant),
    .o_nextRr (w_arbNextRr)
  );

  // The frame buffer shifts left after each byte, so the byte to send is
  // always the top byte.
  assign w_curByte = r_frame[FRAME_W-1 -: 8];
  assign w_srcId   = r_grant ? SRC_ID1 : SRC_ID0;
  assign w_payload = {5'b0, (r_grant ? pos1_i : pos0_i)};

`ifdef UART_SCHED_CKSUM_EN
  assign w_frameInit = {HEADER, w_srcId, w_payload, xorBytes({w_srcId, w_payload})};
`else
  assign w_frameInit = {HEADER, w_srcId, w_payload};
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and strobe decode. The transmit strobe and ack are decoded
  // straight from the state so they can never appear outside SEND / LOAD.
  always_comb begin
    w_nextState = r_state;
    w_pulse     = 1'b0;
    w_ack       = 2'b00;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req_i) w_nextState = ST_LOAD;
      end
      ST_LOAD: begin
        w_ack       = r_grant ? 2'b10 : 2'b01;
        w_nextState = ST_SEND;
      end
      ST_SEND: begin
        if (!tx_busy) begin
          w_pulse     = 1'b1;
          w_nextState = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          w_nextState = ST_WAIT_LO;
        end else if (r_waitCnt == WAIT_LAST) begin
          w_timeout   = 1'b1;
          w_nextState = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) w_nextState = ST_NEXT;
      end
      ST_NEXT: begin
        w_nextState = (r_idx == LAST_IDX) ? ST_IDLE : ST_SEND;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Datapath: arbitration pointer, frame buffer, byte index, timeout counter,
  // sticky error and the last transmitted byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr       <= 1'b0;
      r_grant    <= 1'b0;
      r_idx      <= 4'd0;
      r_frame    <= '0;
      r_waitCnt  <= '0;
      r_err      <= 1'b0;
      r_lastData <= 8'h00;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req_i) begin
            r_grant <= w_arbGrant;
            r_rr    <= w_arbNextRr;
          end
        end
        ST_LOAD: begin
          r_frame <= w_frameInit;
          r_idx   <= 4'd0;
        end
        ST_SEND: begin
          if (w_pulse) begin
            r_lastData <= w_curByte;
            r_waitCnt  <= '0;
          end
        end
        ST_WAIT_HI: begin
          if (w_timeout) begin
            r_err <= 1'b1;
          end else if (!tx_busy) begin
            r_waitCnt <= r_waitCnt + CNT_W'(1);
          end
        end
        ST_NEXT: begin
          if (r_idx != LAST_IDX) begin
            r_idx   <= r_idx + 4'd1;
            r_frame <= r_frame << 8;
          end
        end
        default: ;
      endcase
    end
  end

  assign ack_o        = w_ack;
  assign tx_pluse     = w_pulse;
  assign tx_data      = w_pulse ? w_curByte : r_lastData;
  assign frame_busy_o = (r_state != ST_IDLE);
  assign err_o        = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched. A background process models the
// UART transmitter (busy for a programmable number of cycles after each
// strobe) and logs every strobed byte and every ack. Scenario tasks build
// the expected byte stream from the frame rules and the round-robin rule.
// Honours UART_SCHED_CKSUM_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;
  import uart_sched_pkg::*;

  localparam logic [7:0] HDR = 8'hAA;
  localparam int         BW  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_i;
  logic [42:0] pos0_i;
  logic [42:0] pos1_i;
  logic [1:0]  ack_o;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_pluse;
  logic        frame_busy_o;
  logic        err_o;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] sentQ[$];
  logic [7:0] expQ[$];
  logic [1:0] ackQ[$];
  int busyLen   = 3;
  int busyCnt   = 0;
  bit stuckMode = 1'b0;
  bit busyForce = 1'b0;
  int modelRr   = 0;

  uart_tx_sched #(.HEADER(HDR), .BUSY_WAIT(BW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .pos0_i       (pos0_i),
    .pos1_i       (pos1_i),
    .ack_o        (ack_o),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_pluse     (tx_pluse),
    .frame_busy_o (frame_busy_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  // Transmitter model and logger: drive tx_busy on the falling edge, sample
  // outputs 1 time unit later (still well before the next rising edge).
  initial begin : txModel
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busyForce) tx_busy = 1'b1;
      else           tx_busy = (busyCnt > 0);
      if (busyCnt > 0) busyCnt--;
      #1;
      if (tx_pluse === 1'b1) begin
        sentQ.push_back(tx_data);
        if (!stuckMode) busyCnt = busyLen;
      end
      if (ack_o !== 2'b00) ackQ.push_back(ack_o);
    end
  end

  // Round-robin reference: tie goes to the pointer, then pointer flips to
  // the other source.
  function automatic int pickSource(input logic [1:0] req);
    int g;
    if (req == 2'b11) g = modelRr;
    else              g = req[1] ? 1 : 0;
    modelRr = 1 - g;
    return g;
  endfunction

  // Expected bytes of one frame, appended to expQ.
  function automatic void pushFrame(input int src, input logic [42:0] pay);
    logic [47:0] full;
    full = {5'b0, pay};
    expQ.push_back(HDR);
    expQ.push_back(8'(src));
    for (int i = 5; i >= 0; i--) expQ.push_back(8'((full >> (8 * i)) & 48'hFF));
`ifdef UART_SCHED_CKSUM_EN
    begin
      logic [7:0] ck;
      ck = 8'(src);
      for (int i = 0; i < 6; i++) ck = ck ^ 8'((full >> (8 * i)) & 48'hFF);
      expQ.push_back(ck);
    end
`endif
  endfunction

  function automatic logic [42:0] rndPay();
    return 43'({$urandom(), $urandom()});
  endfunction

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    req_i = 2'b00;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    modelRr = 0;
    sentQ.delete();
    ackQ.delete();
    expQ.delete();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    req_i  = 2'b00;
    pos0_i = '0;
    pos1_i = '0;
    repeat (2) @(negedge clk);
    #2;
    testsRun++; if (tx_pluse !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pulse: got %b expected 0", tx_pluse); end
    testsRun++; if (tx_data !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_data: got %h expected 00", tx_data); end
    testsRun++; if (ack_o !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_ack: got %b expected 00", ack_o); end
    testsRun++; if (frame_busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_fbusy: got %b expected 0", frame_busy_o); end
    testsRun++; if (err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err: got %b expected 0", err_o); end
    @(negedge clk);
    reset   = 1'b0;
    modelRr = 0;
    sentQ.delete();
    ackQ.delete();
    expQ.delete();
  endtask

  task automatic test_single();
    bit ok;
    busyLen = 20;
    @(negedge clk);
    pos0_i = 43'h0123456789A;
    pos1_i = rndPay();
    req_i  = 2'b01;
    pushFrame(pickSource(2'b01), 43'h0123456789A);
    #1;
    testsRun++; if (tx_pluse !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_idle_pulse: got %b expected 0", tx_pluse); end
    @(negedge clk); #1;
    testsRun++; if (ack_o !== 2'b01) begin testsFailed++; $display("[TB] FAIL single_ack_load: got %b expected 01", ack_o); end
    @(negedge clk);
    req_i = 2'b00;
    #1;
    testsRun++; if (tx_pluse !== 1'b1 || tx_data !== HDR) begin testsFailed++; $display("[TB] FAIL single_latency: got pulse=%b data=%h expected 1/%h", tx_pluse, tx_data, HDR); end
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(negedge clk); #2;
      if (sentQ.size() >= expQ.size() && !frame_busy_o) ok = 1'b1;
    end
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL single_timeout: got %0d bytes expected %0d", sentQ.size(), expQ.size()); end
    testsRun++; if (sentQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL single_len: got %0d expected %0d", sentQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < sentQ.size(); i++) begin
      testsRun++; if (sentQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL single_byte%0d: got %h expected %h", i, sentQ[i], expQ[i]); end
    end
    testsRun++; if (ackQ.size() != 1 || ackQ[0] !== 2'b01) begin testsFailed++; $display("[TB] FAIL single_ack_once: got %0d acks expected 1 of 01", ackQ.size()); end
    testsRun++; if (tx_data !== expQ[expQ.size()-1] || tx_pluse !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_hold: got %h/%b expected %h/0", tx_data, tx_pluse, expQ[expQ.size()-1]); end
  endtask

  task automatic test_random();
    bit ok;
    logic [42:0] p0;
    logic [42:0] p1;
    int src;
    for (int f = 0; f < 4; f++) begin
      sentQ.delete(); ackQ.delete(); expQ.delete();
      busyLen = $urandom_range(1, 5);
      src = $urandom_range(0, 1);
      p0 = rndPay();
      p1 = rndPay();
      @(negedge clk);
      pos0_i = p0;
      pos1_i = p1;
      req_i  = (src == 1) ? 2'b10 : 2'b01;
      pushFrame(pickSource(req_i), (src == 1) ? p1 : p0);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
        @(negedge clk);
        if (ackQ.size() > 0) ok = 1'b1;
      end
      req_i  = 2'b00;
      pos0_i = ~p0;
      pos1_i = ~p1;
      testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL rand_ack_timeout: got no ack expected ack for source %0d", src); end
      ok = 1'b0;
      for (int c = 0; c < 1000 && !ok; c++) begin
        @(negedge clk); #2;
        if (sentQ.size() >= expQ.size() && !frame_busy_o) ok = 1'b1;
      end
      testsRun++; if (sentQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL rand_len: got %0d expected %0d", sentQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < sentQ.size(); i++) begin
        testsRun++; if (sentQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL rand_byte%0d: got %h expected %h", i, sentQ[i], expQ[i]); end
      end
    end
  endtask

  task automatic test_pending();
    bit ok;
    logic [42:0] p0;
    logic [42:0] p1;
    sentQ.delete(); ackQ.delete(); expQ.delete();
    busyLen = 3;
    p0 = rndPay();
    p1 = rndPay();
    @(negedge clk);
    pos0_i = p0;
    pos1_i = p1;
    req_i  = 2'b01;
    pushFrame(pickSource(2'b01), p0);
    repeat (3) @(negedge clk);
    req_i = 2'b10;
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk); #2;
      if (sentQ.size() >= expQ.size() && !frame_busy_o) ok = 1'b1;
    end
    testsRun++; if (ackQ.size() != 1) begin testsFailed++; $display("[TB] FAIL pend_no_ack: got %0d acks expected 1", ackQ.size()); end
    pushFrame(pickSource(2'b10), p1);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (ackQ.size() > 1) ok = 1'b1;
    end
    req_i = 2'b00;
    testsRun++; if (!ok || ackQ[ackQ.size()-1] !== 2'b10) begin testsFailed++; $display("[TB] FAIL pend_ack2: got %0d acks expected second ack 10", ackQ.size()); end
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk); #2;
      if (sentQ.size() >= expQ.size() && !frame_busy_o) ok = 1'b1;
    end
    testsRun++; if (sentQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL pend_len: got %0d expected %0d", sentQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < sentQ.size(); i++) begin
      testsRun++; if (sentQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL pend_byte%0d: got %h expected %h", i, sentQ[i], expQ[i]); end
    end
    // A request raised and withdrawn while a frame is in flight is ignored.
    sentQ.delete(); ackQ.delete(); expQ.delete();
    @(negedge clk);
    req_i = 2'b10;
    pushFrame(pickSource(2'b10), p1);
    repeat (2) @(negedge clk);
    req_i = 2'b01;
    repeat (5) @(negedge clk);
    req_i = 2'b00;
    repeat (150) @(negedge clk);
    #2;
    testsRun++; if (sentQ.size() != expQ.size() || frame_busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL withdraw_len: got %0d bytes busy=%b expected %0d/0", sentQ.size(), frame_busy_o, expQ.size()); end
    testsRun++; if (ackQ.size() != 1) begin testsFailed++; $display("[TB] FAIL withdraw_ack: got %0d acks expected 1", ackQ.size()); end
  endtask

  task automatic test_contention();
    bit ok;
    logic [42:0] p0;
    logic [42:0] p1;
    int g;
    applyReset();
    busyLen = 2;
    p0 = rndPay();
    p1 = rndPay();
    pos0_i = p0;
    pos1_i = p1;
    req_i  = 2'b11;
    for (int k = 0; k < 3; k++) begin
      g = pickSource(2'b11);
      pushFrame(g, (g == 1) ? p1 : p0);
    end
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      if (ackQ.size() >= 3) ok = 1'b1;
    end
    req_i = 2'b00;
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk); #2;
      if (sentQ.size() >= expQ.size() && !frame_busy_o) ok = 1'b1;
    end
    testsRun++; if (sentQ.size() != 3 * FRAME_LEN) begin testsFailed++; $display("[TB] FAIL cont_len: got %0d expected %0d", sentQ.size(), 3 * FRAME_LEN); end
    if (sentQ.size() == 3 * FRAME_LEN) begin
      testsRun++; if (sentQ[1] !== 8'h00 || sentQ[FRAME_LEN+1] !== 8'h01 || sentQ[2*FRAME_LEN+1] !== 8'h00) begin testsFailed++; $display("[TB] FAIL cont_ids: got %h %h %h expected 00 01 00", sentQ[1], sentQ[FRAME_LEN+1], sentQ[2*FRAME_LEN+1]); end
    end
    for (int i = 0; i < expQ.size() && i < sentQ.size(); i++) begin
      testsRun++; if (sentQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL cont_byte%0d: got %h expected %h", i, sentQ[i], expQ[i]); end
    end
    testsRun++; if (ackQ.size() != 3) begin testsFailed++; $display("[TB] FAIL cont_ack_count: got %0d expected 3", ackQ.size()); end
    if (ackQ.size() == 3) begin
      testsRun++; if (ackQ[0] !== 2'b01 || ackQ[1] !== 2'b10 || ackQ[2] !== 2'b01) begin testsFailed++; $display("[TB] FAIL cont_ack_order: got %b %b %b expected 01 10 01", ackQ[0], ackQ[1], ackQ[2]); end
    end
  endtask

  task automatic test_stuck();
    bit ok;
    logic [42:0] p1;
    sentQ.delete(); ackQ.delete(); expQ.delete();
    stuckMode = 1'b1;
    p1 = rndPay();
    @(negedge clk);
    pos1_i = p1;
    req_i  = 2'b10;
    pushFrame(pickSource(2'b10), p1);
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      req_i = 2'b00;
      #1;
      if (tx_pluse === 1'b1) ok = 1'b1;
    end
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL stuck_first_pulse: got none expected header strobe"); end
    repeat (BW) @(negedge clk);
    #1;
    testsRun++; if (err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL stuck_err_early: got %b expected 0", err_o); end
    @(negedge clk); #1;
    testsRun++; if (err_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL stuck_err_set: got %b expected 1", err_o); end
    ok = 1'b0;
    for (int c = 0; c < FRAME_LEN * (BW + 6) + 50 && !ok; c++) begin
      @(negedge clk); #2;
      if (sentQ.size() >= expQ.size() && !frame_busy_o) ok = 1'b1;
    end
    testsRun++; if (sentQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL stuck_len: got %0d expected %0d", sentQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < sentQ.size(); i++) begin
      testsRun++; if (sentQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL stuck_byte%0d: got %h expected %h", i, sentQ[i], expQ[i]); end
    end
    testsRun++; if (err_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL stuck_err_sticky: got %b expected 1", err_o); end
    stuckMode = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    bit ok;
    int sz;
    logic [42:0] p0;
    logic [42:0] p1;
    applyReset();
    busyLen   = 4;
    busyForce = 1'b1;
    p0 = rndPay();
    pos0_i = p0;
    req_i  = 2'b01;
    pushFrame(pickSource(2'b01), p0);
    @(negedge clk);
    req_i = 2'b00;
    repeat (15) @(negedge clk);
    #2;
    testsRun++; if (sentQ.size() != 0 || frame_busy_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_hold: got %0d bytes busy=%b expected 0/1", sentQ.size(), frame_busy_o); end
    busyForce = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (sentQ.size() >= 4) ok = 1'b1;
    end
    reset = 1'b1;
    #1;
    testsRun++; if (!ok) begin testsFailed++; $display("[TB] FAIL bp_release: got %0d bytes expected 4", sentQ.size()); end
    for (int i = 0; i < 4 && i < sentQ.size(); i++) begin
      testsRun++; if (sentQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL bp_byte%0d: got %h expected %h", i, sentQ[i], expQ[i]); end
    end
    testsRun++; if (tx_pluse !== 1'b0 || tx_data !== 8'h00 || ack_o !== 2'b00 || frame_busy_o !== 1'b0 || err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_outputs: got p=%b d=%h a=%b fb=%b e=%b expected 0 00 00 0 0", tx_pluse, tx_data, ack_o, frame_busy_o, err_o); end
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    modelRr = 0;
    sz = sentQ.size();
    repeat (40) @(negedge clk);
    #2;
    testsRun++; if (sentQ.size() != sz || frame_busy_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_no_resend: got %0d bytes busy=%b expected %0d/0", sentQ.size(), frame_busy_o, sz); end
    sentQ.delete(); ackQ.delete(); expQ.delete();
    p1 = rndPay();
    @(negedge clk);
    pos1_i = p1;
    req_i  = 2'b10;
    pushFrame(pickSource(2'b10), p1);
    @(negedge clk);
    req_i = 2'b00;
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk); #2;
      if (sentQ.size() >= expQ.size() && !frame_busy_o) ok = 1'b1;
    end
    testsRun++; if (sentQ.size() != expQ.size()) begin testsFailed++; $display("[TB] FAIL post_len: got %0d expected %0d", sentQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < sentQ.size(); i++) begin
      testsRun++; if (sentQ[i] !== expQ[i]) begin testsFailed++; $display("[TB] FAIL post_byte%0d: got %h expected %h", i, sentQ[i], expQ[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_pending();
    test_contention();
    test_stuck();
    test_backpressure_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
